// File: rtl/pad_io_pkg.sv
// Shared definitions for the pad data interface: transmit FSM states,
// outbound pad bus field layout and the frame packing helper.
package pad_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ASSERT,
        DEASSERT
    } tx_state_t;

    localparam int PAD_DATA_LSB   = 0;
    localparam int PAD_STROBE_BIT = 8;
    localparam int PAD_LAST_BIT   = 9;
    localparam int PAD_PARITY_BIT = 10;
    localparam int PAD_OUT_W      = 11;
    localparam int BYTES_PER_WORD = 4;

    // Even parity covers the data byte and the last flag (9 bits).
    function automatic logic [PAD_OUT_W-1:0] pad_frame(
        input logic [7:0] data,
        input logic       last,
        input logic       strobe
    );
        logic [PAD_OUT_W-1:0] frame;
        frame                      = '0;
        frame[PAD_DATA_LSB +: 8]   = data;
        frame[PAD_STROBE_BIT]      = strobe;
        frame[PAD_LAST_BIT]        = last;
        frame[PAD_PARITY_BIT]      = (^data) ^ last;
        return frame;
    endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-stage single-bit synchronizer for asynchronous pad inputs.
module pad_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/pad_tx_streamer.sv
// Serializes 32-bit core words MSB-byte-first onto the outbound pad bus,
// pacing each byte with a four-phase strobe/ack exchange and a timeout abort.
module pad_tx_streamer
    import pad_io_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT     = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 pad_clk,
    input  logic                 pad_rst_n,
    input  logic [31:0]          tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 host_ack,
    input  logic                 err_clr,
    output logic [PAD_OUT_W-1:0] bidir_output_data,
    output logic                 tx_done,
    output logic                 tx_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    tx_state_t            state_reg, state_next;
    logic [31:0]          word_reg, word_next;
    logic [1:0]           idx_reg, idx_next;
    logic [3:0]           setup_cnt_reg, setup_cnt_next;
    logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
    logic [PAD_OUT_W-1:0] bus_reg, bus_next;
    logic                 done_reg, done_next;
    logic                 err_reg, err_set;
    logic                 ack_sync;
    logic [7:0]           word_bytes [BYTES_PER_WORD];

    pad_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (pad_clk),
        .rst_n(pad_rst_n),
        .din  (host_ack),
        .dout (ack_sync)
    );

    assign tx_ready = pad_rst_n && (state_reg == IDLE);

    always_comb begin
        state_next     = state_reg;
        word_next      = word_reg;
        idx_next       = idx_reg;
        setup_cnt_next = setup_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        done_next      = 1'b0;
        err_set        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    word_next      = tx_data;
                    idx_next       = 2'd0;
                    setup_cnt_next = 4'd0;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_reg == 4'(SETUP_CYC - 1)) begin
                    to_cnt_next = '0;
                    state_next  = ASSERT;
                end else begin
                    setup_cnt_next = setup_cnt_reg + 4'd1;
                end
            end
            ASSERT: begin
                if (ack_sync) begin
                    to_cnt_next = '0;
                    state_next  = DEASSERT;
                end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            DEASSERT: begin
                if (!ack_sync) begin
                    if (idx_reg == 2'(BYTES_PER_WORD - 1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next       = idx_reg + 2'd1;
                        setup_cnt_next = 4'd0;
                        state_next     = SETUP;
                    end
                end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte 0 of the transfer order is the most significant byte of the word.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
        assign word_bytes[gi] = word_next[8*(BYTES_PER_WORD-1-gi) +: 8];
    end

    // The bus register is loaded from the next state so every field is a flop.
    always_comb begin
        bus_next = '0;
        if (state_next != IDLE) begin
            bus_next = pad_frame(word_bytes[idx_next],
                                 idx_next == 2'(BYTES_PER_WORD - 1),
                                 state_next == ASSERT);
        end
    end

    always_ff @(posedge pad_clk) begin
        if (!pad_rst_n) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            idx_reg       <= '0;
            setup_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            bus_reg       <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            word_reg      <= word_next;
            idx_reg       <= idx_next;
            setup_cnt_reg <= setup_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            bus_reg       <= bus_next;
            done_reg      <= done_next;
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign bidir_output_data = bus_reg;
    assign tx_done           = done_reg;
    assign tx_err            = err_reg;

endmodule
